// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter that shares one external memory bus channel between
// the I-fetch (port 0), load (port 1) and store (port 2) controllers.
// The winning command is latched and held on the bus outputs until the bus
// controller signals completion, which is routed back to the owning port.
module memory_port_arbiter #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 halt_i,
  input  logic [NUM_PORTS-1:0]                 port_request_i,
  input  logic [NUM_PORTS-1:0]                 port_write_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_address_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_data_i,
  input  logic [NUM_PORTS-1:0][1:0]            port_width_i,
  output logic [NUM_PORTS-1:0]                 port_grant_o,
  output logic [NUM_PORTS-1:0]                 port_done_o,
  output logic [DATA_WIDTH-1:0]                port_data_o,
  output logic                                 bus_request_o,
  output logic                                 bus_write_o,
  output logic [ADDR_WIDTH-1:0]                bus_address_o,
  output logic [DATA_WIDTH-1:0]                bus_data_o,
  output logic [1:0]                           bus_width_o,
  input  logic                                 bus_done_i,
  input  logic [DATA_WIDTH-1:0]                bus_data_i,
  output logic                                 busy_o
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     idx;
  logic [NUM_PORTS-1:0] mask_port;
  logic [NUM_PORTS-1:0] eligible;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_valid;
  logic                 done_accept;

  // (base + off) mod NUM_PORTS, for off < NUM_PORTS
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return sum[IDX_W-1:0];
  endfunction

  function automatic logic [NUM_PORTS-1:0] one_hot(input logic [IDX_W-1:0] i);
    logic [NUM_PORTS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Pick the first eligible port scanning upward from rr_ptr with wrap
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    eligible  = port_request_i & ~mask_port;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!win_valid && eligible[wrap_add(rr_ptr, i)]) begin
        win_valid = 1'b1;
        win_idx   = wrap_add(rr_ptr, i);
      end
    end
  end

  // Done is accepted only while waiting; halt never blocks it
  assign done_accept   = (state == WAIT) && bus_done_i;
  assign bus_request_o = (state == ISSUE) && !halt_i;
  assign port_done_o   = done_accept ? one_hot(idx) : '0;
  assign port_data_o   = done_accept ? bus_data_i : '0;
  assign busy_o        = (state != IDLE);

  // Arbitration FSM: grant and latch in IDLE, issue once, wait for done
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the latched command is cleared on reset because it drives the
      // bus outputs directly and must read as zero out of reset.
      state         <= IDLE;
      rr_ptr        <= '0;
      idx           <= '0;
      mask_port     <= '0;
      port_grant_o  <= '0;
      bus_write_o   <= 1'b0;
      bus_address_o <= '0;
      bus_data_o    <= '0;
      bus_width_o   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      unique case (state)
        IDLE: begin
          mask_port <= '0;
          if (win_valid && !halt_i) begin
            idx           <= win_idx;
            port_grant_o  <= one_hot(win_idx);
            bus_write_o   <= port_write_i[win_idx];
            bus_address_o <= port_address_i[win_idx];
            bus_data_o    <= port_data_i[win_idx];
            bus_width_o   <= port_width_i[win_idx];
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!halt_i) state <= WAIT;
        end
        WAIT: begin
          if (bus_done_i) begin
            rr_ptr       <= wrap_add(idx, 1);
            mask_port    <= one_hot(idx);
            port_grant_o <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
